// File: rtl/rst_seq_ctrl.sv
// ============================================================================
// rst_seq_ctrl
// ----------------------------------------------------------------------------
// Power-on / lock-driven reset sequencer. It holds every downstream reset
// asserted for a minimum time and then waits for a filtered clock-generator
// lock. After that it releases the channel resets one at a time, in order
// 0..N_CH-1, with STEP_CYC cycles between releases. Once the last channel is
// released the block sits in RUN.
//
// Losing lock while releasing or running drops straight back to HOLD and
// bumps a saturating event counter. A software request also drops back to
// HOLD, but it is not counted.
//
// Parameters
//   N_CH          number of sequenced reset outputs (1..16)
//   HOLD_CYC      cycles spent in HOLD with every reset asserted (>= 1)
//   LOCK_FILT_CYC consecutive synchronized lock cycles needed (>= 1)
//   STEP_CYC      cycles between successive channel releases (>= 1)
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   lock_in       clock-generator lock flag, asynchronous to clk
//   sw_rst_req    synchronous request to re-run the whole sequence
//   rst_out       registered active-high per-channel resets
//   done          registered, high once every channel is released
//   state_o       HOLD=0, WAIT_LOCK=1, RELEASE=2, RUN=3
//   lock_loss_cnt saturating count of lock losses in RELEASE/RUN
// ============================================================================
module rst_seq_ctrl #(
    parameter int N_CH          = 4,
    parameter int HOLD_CYC      = 200,
    parameter int LOCK_FILT_CYC = 64,
    parameter int STEP_CYC      = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lock_in,
    input  logic            sw_rst_req,
    output logic [N_CH-1:0] rst_out,
    output logic            done,
    output logic [1:0]      state_o,
    output logic [7:0]      lock_loss_cnt
);

    // ------------------------------------------------------------------------
    // Parameter legality, caught at elaboration
    // ------------------------------------------------------------------------
    generate
        if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
            $error("rst_seq_ctrl: N_CH must lie in 1..16");
        end
        if (HOLD_CYC < 1) begin : g_bad_hold
            $error("rst_seq_ctrl: HOLD_CYC must be >= 1");
        end
        if (LOCK_FILT_CYC < 1) begin : g_bad_filt
            $error("rst_seq_ctrl: LOCK_FILT_CYC must be >= 1");
        end
        if (STEP_CYC < 1) begin : g_bad_step
            $error("rst_seq_ctrl: STEP_CYC must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State encoding and counter sizing
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_HOLD      = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_RELEASE   = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    // Each counter only ever holds 0..PARAM-1, so clog2 of the parameter is
    // enough. A floor of one bit keeps the degenerate PARAM==1 case legal.
    localparam int HOLD_W = (HOLD_CYC      > 1) ? $clog2(HOLD_CYC)      : 1;
    localparam int FILT_W = (LOCK_FILT_CYC > 1) ? $clog2(LOCK_FILT_CYC) : 1;
    localparam int STEP_W = (STEP_CYC      > 1) ? $clog2(STEP_CYC)      : 1;
    localparam int CH_W   = (N_CH          > 1) ? $clog2(N_CH)          : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT_CYC - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic              sync1_reg;
    logic              lock_s_reg;

    logic [1:0]        state_reg,         state_next;
    logic [HOLD_W-1:0] hold_cnt_reg,      hold_cnt_next;
    logic [FILT_W-1:0] filt_cnt_reg,      filt_cnt_next;
    logic [STEP_W-1:0] step_cnt_reg,      step_cnt_next;
    logic [CH_W-1:0]   ch_idx_reg,        ch_idx_next;
    logic [N_CH-1:0]   rst_out_reg,       rst_out_next;
    logic              done_reg,          done_next;
    logic [7:0]        lock_loss_cnt_reg, lock_loss_cnt_next;

    // ------------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous lock flag. Everything
    // downstream looks only at lock_s_reg.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg  <= 1'b0;
            lock_s_reg <= 1'b0;
        end else begin
            sync1_reg  <= lock_in;
            lock_s_reg <= sync1_reg;
        end
    end

    // ------------------------------------------------------------------------
    // Decode of the events that pull the sequencer back to HOLD
    // ------------------------------------------------------------------------
    logic lock_lost;
    logic go_hold;
    logic step_tick;
    logic rel_fire;
    logic force_all;

    // Lock only matters once the release has begun. In HOLD and WAIT_LOCK
    // a missing lock is the normal condition, not a loss.
    assign lock_lost = ((state_reg == ST_RELEASE) || (state_reg == ST_RUN))
                       && !lock_s_reg;

    // A software request coinciding with a lock loss takes the same path.
    // Only lock_lost feeds the event counter, so the pair counts once.
    assign go_hold   = lock_lost || sw_rst_req;

    assign step_tick = (state_reg == ST_RELEASE) && (step_cnt_reg == STEP_LAST);

    // A release edge is cancelled if the same edge returns to HOLD.
    assign rel_fire  = step_tick && !go_hold;

    // Every reset is held asserted while not yet releasing, and on any return
    // to HOLD.
    assign force_all = go_hold
                       || (state_reg == ST_HOLD)
                       || (state_reg == ST_WAIT_LOCK);

    // ------------------------------------------------------------------------
    // Per-channel reset output next-value. A channel drops only on the
    // release edge addressed to it. It stays low until force_all reasserts it.
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign rst_out_next[gi] =
                force_all                                  ? 1'b1 :
                (rel_fire && (ch_idx_reg == CH_W'(gi)))    ? 1'b0 :
                                                             rst_out_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Sequencer next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next         = state_reg;
        hold_cnt_next      = hold_cnt_reg;
        filt_cnt_next      = filt_cnt_reg;
        step_cnt_next      = step_cnt_reg;
        ch_idx_next        = ch_idx_reg;
        done_next          = done_reg;
        lock_loss_cnt_next = lock_loss_cnt_reg;

        if (go_hold) begin
            // Every entry to HOLD starts from a clean slate. A request held
            // high while already in HOLD keeps restarting the hold window.
            state_next    = ST_HOLD;
            hold_cnt_next = '0;
            filt_cnt_next = '0;
            step_cnt_next = '0;
            ch_idx_next   = '0;
            done_next     = 1'b0;
            if (lock_lost && (lock_loss_cnt_reg != 8'hFF)) begin
                lock_loss_cnt_next = lock_loss_cnt_reg + 8'd1;
            end
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    done_next = 1'b0;
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_next    = ST_WAIT_LOCK;
                        hold_cnt_next = '0;
                        filt_cnt_next = '0;
                    end else begin
                        hold_cnt_next = hold_cnt_reg + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    // Count only an unbroken run of locked cycles. Any
                    // unlocked cycle starts the filter over.
                    if (!lock_s_reg) begin
                        filt_cnt_next = '0;
                    end else if (filt_cnt_reg == FILT_LAST) begin
                        state_next    = ST_RELEASE;
                        filt_cnt_next = '0;
                        step_cnt_next = '0;
                        ch_idx_next   = '0;
                    end else begin
                        filt_cnt_next = filt_cnt_reg + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    if (step_tick) begin
                        step_cnt_next = '0;
                        if (ch_idx_reg == CH_LAST) begin
                            // The edge that releases the last channel also
                            // declares the sequence complete.
                            state_next = ST_RUN;
                            done_next  = 1'b1;
                        end else begin
                            ch_idx_next = ch_idx_reg + 1'b1;
                        end
                    end else begin
                        step_cnt_next = step_cnt_reg + 1'b1;
                    end
                end

                ST_RUN: begin
                    done_next = 1'b1;
                end

                default: begin
                    state_next = ST_HOLD;
                    done_next  = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_HOLD;
            hold_cnt_reg      <= '0;
            filt_cnt_reg      <= '0;
            step_cnt_reg      <= '0;
            ch_idx_reg        <= '0;
            rst_out_reg       <= '1;
            done_reg          <= 1'b0;
            lock_loss_cnt_reg <= 8'd0;
        end else begin
            state_reg         <= state_next;
            hold_cnt_reg      <= hold_cnt_next;
            filt_cnt_reg      <= filt_cnt_next;
            step_cnt_reg      <= step_cnt_next;
            ch_idx_reg        <= ch_idx_next;
            rst_out_reg       <= rst_out_next;
            done_reg          <= done_next;
            lock_loss_cnt_reg <= lock_loss_cnt_next;
        end
    end

    assign rst_out       = rst_out_reg;
    assign done          = done_reg;
    assign state_o       = state_reg;
    assign lock_loss_cnt = lock_loss_cnt_reg;

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL provide parameter N_CH, default 4, number of sequenced reset outputs; legal range 1..16.
REQ-002 SHALL provide parameter HOLD_CYC, default 200, minimum number of cycles all resets stay asserted; must be >= 1.
REQ-003 SHALL provide parameter LOCK_FILT_CYC, default 64, number of consecutive synchronized lock_in-high cycles required before release starts; must be >= 1.
REQ-004 SHALL provide parameter STEP_CYC, default 16, cycles between successive channel releases; must be >= 1.
REQ-005 SHALL provide port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL provide port lock_in, input, 1 bit: clock-generator locked flag, asynchronous to clk.
REQ-008 SHALL provide port sw_rst_req, input, 1 bit: synchronous request to re-run the sequence.
REQ-009 SHALL provide port rst_out, output, N_CH bits: active-high per-channel resets, registered.
REQ-010 SHALL provide port done, output, 1 bit: all channels released.
REQ-011 SHALL provide port state_o, output, 2 bits: HOLD=0, WAIT_LOCK=1, RELEASE=2, RUN=3.
REQ-012 SHALL provide port lock_loss_cnt, output, 8 bits: saturating count of lock losses.

Function
REQ-013 SHALL pass lock_in through a 2-flop synchronizer; lock_s denotes the synchronizer output, and every other rule uses lock_s.
REQ-014 HOLD SHALL keep rst_out all ones and done=0; it SHALL leave to WAIT_LOCK after exactly HOLD_CYC cycles in HOLD; lock_s is ignored in HOLD.
REQ-015 WAIT_LOCK SHALL count consecutive lock_s=1 cycles.
REQ-016 WAIT_LOCK SHALL clear that count on any lock_s=0 cycle.
REQ-017 WAIT_LOCK SHALL enter RELEASE with channel index 0 when the count reaches LOCK_FILT_CYC.
REQ-018 In RELEASE, rst_out[i] SHALL fall exactly (i+1)*STEP_CYC cycles after the first RELEASE cycle, strictly in order 0..N_CH-1.
REQ-019 A released channel SHALL stay low until the next return to HOLD.
REQ-020 The edge that releases channel N_CH-1 SHALL also enter RUN and set done=1.
REQ-021 RUN SHALL hold rst_out all zeros and done=1 indefinitely, absent lock loss, sw_rst_req or rst.
REQ-022 Lock loss (lock_s=0 while in RELEASE or RUN) SHALL enter HOLD on the next edge, setting rst_out all ones and done=0.
REQ-023 With the REQ-022 latency, rst_out SHALL be all ones on the 3rd rising edge after lock_in falls.
REQ-024 Each lock loss SHALL increment lock_loss_cnt by 1, saturating at 255 with no wrap.
REQ-025 sw_rst_req=1 in any state SHALL enter HOLD on the next edge, with all rst_out asserted and the hold counter restarted.
REQ-026 sw_rst_req=1 held in HOLD SHALL keep restarting the hold counter, extending HOLD.
REQ-027 sw_rst_req SHALL NOT increment lock_loss_cnt.
REQ-028 Simultaneous lock loss and sw_rst_req SHALL be treated as lock loss: enter HOLD and increment the count once.
REQ-029 Every entry to HOLD SHALL clear the step counter, the filter counter and the channel index.
REQ-030 All counters SHALL be sized by clog2 of their parameter and SHALL NOT wrap within any state.
REQ-031 Illegal parameter values SHALL be reported by an elaboration-time error.

Reset
REQ-032 rst=1 SHALL, at the next edge, force state HOLD, rst_out all ones, done=0, state_o=0 and lock_loss_cnt=0.
REQ-033 rst=1 SHALL also clear all counters, the channel index and both synchronizer flops.
REQ-034 rst SHALL take priority over lock loss and sw_rst_req.
REQ-035 Normal sequencing SHALL restart from HOLD on the first edge with rst=0.
REQ-036 rst asserted mid-RELEASE or mid-RUN SHALL behave identically to power-up reset.

Verification (N_CH=3, HOLD_CYC=8, LOCK_FILT_CYC=5, STEP_CYC=4)
REQ-037 Power-up: rst low at edge 0, lock_in=1 throughout -> HOLD for edges 0-7, WAIT_LOCK for 5 cycles, then rst_out=110/100/000 at RELEASE+4/+8/+12 and done=1 at +12.
REQ-038 Filter glitch: in WAIT_LOCK, 3 cycles of lock_s=1, then 1 cycle low, then high -> RELEASE entered 5 cycles after re-rise and lock_loss_cnt stays 0.
REQ-039 Lock loss in RUN: lock_in low for 10 cycles -> rst_out=111 and done=0 on the 3rd edge, lock_loss_cnt=1, then the full sequence repeats after lock returns.
REQ-040 sw_rst_req for 1 cycle after channel 0 released -> rst_out=111 on the next edge, lock_loss_cnt unchanged, HOLD lasts 8 cycles.
REQ-041 260 lock-loss events -> lock_loss_cnt=255, with no wrap.
REQ-042 Coincident and mid-sequence resets:
- rst pulse mid-RELEASE -> rst_out=111, done=0, count=0 next edge.
- Coincident lock loss and sw_rst_req -> count +1 exactly.
